result_bcd_decoder: RTL and testbench

Sequential binary-to-BCD decoder on the result side of the two-function calculator. It accepts one 8-bit adder/subtractor result, plus that result's overflow flag and a signed/unsigned mode bit. It produces a sign flag and three BCD digits (hundreds, tens, ones) for the display drivers. Conversion is iterative shift-add-3 (double dabble): one magnitude bit per clock, under a start/busy/done handshake.

---
 rtl/result_bcd_decoder.sv | 144 ++++++++++++++
 tb/tb_result_bcd_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/result_bcd_decoder.sv
// Sequential 8-bit binary-to-BCD decoder (double dabble, one bit per clock)
// with sign extraction and an overflow flag carried alongside the result.
`timescale 1ns/1ps
module result_bcd_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       is_signed,
    input  logic       ovr_in,
    output logic       busy,
    output logic       done,
    output logic       sign,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       err
);

    localparam int unsigned DW    = 8;
    localparam int unsigned DIGW  = 4;
    localparam int unsigned NDIG  = 3;
    localparam int unsigned ACCW  = DIGW * NDIG;
    localparam int unsigned CNTW  = 3;

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state_q, state_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [DW-1:0]     mag_q, mag_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              sign_n_q, sign_n_d;
    logic              err_n_q, err_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sign_q, sign_d;
    logic [DIGW-1:0]   hund_q, hund_d;
    logic [DIGW-1:0]   tens_q, tens_d;
    logic [DIGW-1:0]   ones_q, ones_d;
    logic              err_q, err_d;

    logic [ACCW-1:0]   acc_adj;
    logic [ACCW-1:0]   acc_sh;
    logic              neg_in;

    // Add-3 correction on every nibble that would overflow past 9 after doubling
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < NDIG; i++) begin
            if (acc_q[i*DIGW +: DIGW] >= DIGW'(5))
                acc_adj[i*DIGW +: DIGW] = acc_q[i*DIGW +: DIGW] + DIGW'(3);
        end
    end

    assign acc_sh = ACCW'({acc_adj, mag_q[DW-1]});
    assign neg_in = is_signed & din[DW-1];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        sign_n_d = sign_n_q;
        err_n_d  = err_n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sign_d   = sign_q;
        hund_d   = hund_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_n_d = neg_in;
                    mag_d    = neg_in ? DW'((~din) + DW'(1)) : din;
                    err_n_d  = ovr_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CONV;
                end
            end
            CONV: begin
                acc_d = acc_sh;
                mag_d = {mag_q[DW-2:0], 1'b0};
                cnt_d = cnt_q + CNTW'(1);
                // Eighth shift: publish the finished digits
                if (cnt_q == CNTW'(DW - 1)) begin
                    hund_d  = acc_sh[2*DIGW +: DIGW];
                    tens_d  = acc_sh[DIGW +: DIGW];
                    ones_d  = acc_sh[0 +: DIGW];
                    sign_d  = sign_n_q;
                    err_d   = err_n_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mag_q    <= '0;
            cnt_q    <= '0;
            sign_n_q <= 1'b0;
            err_n_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sign_q   <= 1'b0;
            hund_q   <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            sign_n_q <= sign_n_d;
            err_n_q  <= err_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sign_q   <= sign_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            err_q    <= err_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sign = sign_q;
    assign hund = hund_q;
    assign tens = tens_q;
    assign ones = ones_q;
    assign err  = err_q;

endmodule

// File: tb/tb_result_bcd_decoder.sv
// Scoreboard bench for result_bcd_decoder: expected digits come from a
// decimal-arithmetic model; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_result_bcd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       is_signed;
    logic       ovr_in;
    logic       busy, done, sign, err;
    logic [3:0] hund, tens, ones;

    typedef struct packed {
        logic       sign;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       err;
    } res_t;

    res_t exp_q[$];
    res_t last;
    res_t mon_r;
    int   checks   = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    result_bcd_decoder dut (
        .clk(clk), .rst(rst), .start(start), .din(din),
        .is_signed(is_signed), .ovr_in(ovr_in),
        .busy(busy), .done(done), .sign(sign),
        .hund(hund), .tens(tens), .ones(ones), .err(err)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [7:0] d, input logic s, input logic o);
        res_t r;
        int   v, m;
        v = s ? int'(signed'(d)) : int'(d);
        m = (v < 0) ? -v : v;
        r.sign = (v < 0);
        r.h    = 4'(m / 100);
        r.t    = 4'((m / 10) % 10);
        r.o    = 4'(m % 10);
        r.err  = o;
        return r;
    endfunction

    function automatic int outs();
        return int'({sign, hund, tens, ones, err});
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", int'(done), 0);
            end else begin
                mon_r = exp_q.pop_front();
                check("result", outs(), int'(mon_r));
                check("busy_at_done", int'(busy), 0);
            end
            check("done_one_cycle", int'(prev_done), 0);
        end
        prev_done = rst ? 1'b0 : done;
    end

    // Starts a conversion in the current cycle; optionally re-pulses start
    // while busy (spur = edge index at which the ignored start is sampled).
    task automatic convert(input logic [7:0] d, input logic s, input logic o, input int spur);
        res_t r;
        int   n;
        r = model(d, s, o);
        din = d; is_signed = s; ovr_in = o; start = 1'b1;
        exp_q.push_back(r);
        @(posedge clk); #1;
        start = 1'b0; din = 8'($urandom); is_signed = 1'($urandom); ovr_in = 1'($urandom);
        check("busy_after_start", int'(busy), 1);
        check("hold_at_start", outs(), int'(last));
        n = 0;
        while (n < 20) begin
            if (spur > 0 && n == spur - 1) begin
                start = 1'b1; din = 8'($urandom);
            end else if (spur > 0 && n == spur) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done) break;
            check("busy_during_conv", int'(busy), 1);
        end
        start = 1'b0;
        check("latency", n, 8);
        last = r;
    endtask

    task automatic hold_cycles(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            din = 8'($urandom); is_signed = ~is_signed; ovr_in = 1'($urandom);
            @(posedge clk); #1;
            check("hold_outputs", outs(), int'(last));
            check("hold_busy", int'(busy), 0);
            check("hold_done", int'(done), 0);
        end
    endtask

    initial begin
        int spur;
        rst = 1'b1; start = 1'b0; din = 8'h00; is_signed = 1'b0; ovr_in = 1'b0;
        last = '0;
        #12;
        check("reset_outputs", outs(), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        convert(8'hFF, 1'b0, 1'b0, 0);
        check("unsigned_max", outs(), int'({1'b0, 4'd2, 4'd5, 4'd5, 1'b0}));
        convert(8'h80, 1'b1, 1'b0, 0);
        check("signed_min", outs(), int'({1'b1, 4'd1, 4'd2, 4'd8, 1'b0}));
        convert(8'hF6, 1'b1, 1'b1, 0);
        check("signed_neg_ovr", outs(), int'({1'b1, 4'd0, 4'd1, 4'd0, 1'b1}));
        convert(8'h00, 1'b0, 1'b0, 0);
        check("zero_clears_err", outs(), 0);

        // Ignored start at E3, then a start in the done cycle
        convert(8'h2A, 1'b0, 1'b0, 3);
        check("start_while_busy", outs(), int'({1'b0, 4'd0, 4'd4, 4'd2, 1'b0}));
        convert(8'h63, 1'b0, 1'b0, 0);
        check("start_in_done_cycle", outs(), int'({1'b0, 4'd0, 4'd9, 4'd9, 1'b0}));

        hold_cycles(20);

        // Abort between E4 and E5
        din = 8'h7F; is_signed = 1'b0; ovr_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_outputs", outs(), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("no_done_after_abort", int'(done), 0);
            check("idle_after_abort", int'(busy), 0);
        end

        for (int k = 0; k < 40; k++) begin
            spur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            convert(8'($urandom), 1'($urandom), 1'($urandom), spur);
            if ($urandom_range(0, 1) == 1) hold_cycles(int'($urandom_range(1, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
